// File: rtl/mmio_bus_controller.sv
// rtl/mmio_bus_controller.sv - single-outstanding load/store steering to DMEM or KEY/SW/HEX/LEDR registers
// Optional MMIO_KEY_STICKY_EN: KEY reads return press-edge sticky bits, cleared by the read.
module mmio_bus_controller #(
  parameter int               DBITS        = 32,
  parameter int               DMEMADDRBITS = 13,
  parameter int               DMEMWORDBITS = 2,
  parameter int               DMEMWORDS    = 2048,
  parameter logic [DBITS-1:0] ADDR_HEX     = 32'hF0000000,
  parameter logic [DBITS-1:0] ADDR_LEDR    = 32'hF0000004,
  parameter logic [DBITS-1:0] ADDR_KEY     = 32'hF0000010,
  parameter logic [DBITS-1:0] ADDR_SW      = 32'hF0000014
) (
  input  logic                                 clk,
  input  logic                                 reset,
  input  logic                                 req_valid,
  input  logic                                 req_we,
  input  logic [DBITS-1:0]                     req_addr,
  input  logic [DBITS-1:0]                     req_wdata,
  output logic                                 req_ready,
  output logic                                 rsp_valid,
  output logic [DBITS-1:0]                     rsp_rdata,
  output logic                                 rsp_err,
  output logic [DMEMADDRBITS-DMEMWORDBITS-1:0] dmem_addr,
  output logic                                 dmem_we,
  output logic [DBITS-1:0]                     dmem_wdata,
  input  logic [DBITS-1:0]                     dmem_rdata,
  input  logic [3:0]                           key_in,
  input  logic [9:0]                           sw_in,
  output logic [15:0]                          hex_out,
  output logic [9:0]                           ledr_out
);

  localparam int               WA         = DMEMADDRBITS - DMEMWORDBITS;
  localparam logic [DBITS-1:0] DMEM_LIMIT = DBITS'(DMEMWORDS) << DMEMWORDBITS;

  typedef enum logic [1:0] {S_IDLE, S_DMEM_ACC, S_DMEM_RSP, S_IO_RSP} state_t;

  state_t            r_state;
  logic [WA-1:0]     r_dmem_addr;
  logic              r_we;
  logic [DBITS-1:0]  r_wdata;
  logic [DBITS-1:0]  r_io_rdata;
  logic              r_io_err;
  logic [15:0]       r_hex;
  logic [9:0]        r_ledr;
  logic [3:0]        r_key_s1, r_key_s2;
  logic [9:0]        r_sw_s1, r_sw_s2;

  logic              w_accept, w_misalign, w_hit_dmem, w_is_dmem, w_is_io, w_rsp;
  logic              w_hit_hex, w_hit_ledr, w_hit_key, w_hit_sw;
  logic [3:0]        w_key_rd;
  logic [DBITS-1:0]  w_io_rdata;

  assign req_ready  = (r_state == S_IDLE) && !reset;
  assign w_accept   = req_valid && req_ready;
  assign w_misalign = req_addr[DMEMWORDBITS-1:0] != '0;
  assign w_hit_dmem = (req_addr[DBITS-1:DMEMADDRBITS] == '0) && (req_addr < DMEM_LIMIT);
  assign w_hit_hex  = req_addr == ADDR_HEX;
  assign w_hit_ledr = req_addr == ADDR_LEDR;
  assign w_hit_key  = req_addr == ADDR_KEY;
  assign w_hit_sw   = req_addr == ADDR_SW;
  assign w_is_dmem  = !w_misalign && w_hit_dmem;
  assign w_is_io    = !w_misalign && !w_hit_dmem && (w_hit_hex || w_hit_ledr || w_hit_key || w_hit_sw);

`ifdef MMIO_KEY_STICKY_EN
  logic [3:0] r_key_s3;
  logic [3:0] r_key_sticky;
  logic       w_key_clear;

  // A press edge in the same cycle as the clearing read survives the clear.
  assign w_key_clear = w_accept && !req_we && w_hit_key;
  assign w_key_rd    = r_key_sticky;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_key_s3     <= 4'hF;
      r_key_sticky <= 4'h0;
    end else begin
      r_key_s3     <= r_key_s2;
      r_key_sticky <= (w_key_clear ? 4'h0 : r_key_sticky) | (r_key_s3 & ~r_key_s2);
    end
  end
`else
  assign w_key_rd = ~r_key_s2;
`endif

  always_comb begin
    w_io_rdata = '0;
    if (w_hit_hex)       w_io_rdata = {{(DBITS-16){1'b0}}, r_hex};
    else if (w_hit_ledr) w_io_rdata = {{(DBITS-10){1'b0}}, r_ledr};
    else if (w_hit_key)  w_io_rdata = {{(DBITS-4){1'b0}}, w_key_rd};
    else if (w_hit_sw)   w_io_rdata = {{(DBITS-10){1'b0}}, r_sw_s2};
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state     <= S_IDLE;
      r_dmem_addr <= '0;
      r_we        <= 1'b0;
      r_wdata     <= '0;
      r_io_rdata  <= '0;
      r_io_err    <= 1'b0;
      r_hex       <= '0;
      r_ledr      <= '0;
      r_key_s1    <= 4'hF;
      r_key_s2    <= 4'hF;
      r_sw_s1     <= '0;
      r_sw_s2     <= '0;
    end else begin
      r_key_s1 <= key_in;
      r_key_s2 <= r_key_s1;
      r_sw_s1  <= sw_in;
      r_sw_s2  <= r_sw_s1;
      case (r_state)
        S_IDLE: begin
          if (w_accept) begin
            r_we        <= req_we;
            r_wdata     <= req_wdata;
            r_dmem_addr <= req_addr[DMEMADDRBITS-1:DMEMWORDBITS];
            if (w_is_dmem) begin
              r_state <= S_DMEM_ACC;
            end else begin
              // IO and error requests both finish in IO_RSP; errors have no side effects.
              r_state    <= S_IO_RSP;
              r_io_err   <= !w_is_io;
              r_io_rdata <= (w_is_io && !req_we) ? w_io_rdata : '0;
              if (w_is_io && req_we && w_hit_hex)  r_hex  <= req_wdata[15:0];
              if (w_is_io && req_we && w_hit_ledr) r_ledr <= req_wdata[9:0];
            end
          end
        end
        S_DMEM_ACC: r_state <= r_we ? S_IDLE : S_DMEM_RSP;
        S_DMEM_RSP: r_state <= S_IDLE;
        S_IO_RSP:   r_state <= S_IDLE;
        default:    r_state <= S_IDLE;
      endcase
    end
  end

  assign w_rsp = !reset && ((r_state == S_DMEM_ACC && r_we) ||
                            r_state == S_DMEM_RSP || r_state == S_IO_RSP);

  assign rsp_valid  = w_rsp;
  assign rsp_rdata  = (w_rsp && r_state == S_DMEM_RSP) ? dmem_rdata :
                      (w_rsp && r_state == S_IO_RSP)   ? r_io_rdata : '0;
  assign rsp_err    = w_rsp && (r_state == S_IO_RSP) && r_io_err;
  assign dmem_addr  = r_dmem_addr;
  assign dmem_we    = !reset && (r_state == S_DMEM_ACC) && r_we;
  assign dmem_wdata = r_wdata;
  assign hex_out    = r_hex;
  assign ledr_out   = r_ledr;

endmodule

// File: tb/tb_mmio_bus_controller.sv
// tb/tb_mmio_bus_controller.sv - directed bench for mmio_bus_controller
module tb_mmio_bus_controller;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        req_valid = 1'b0;
  logic        req_we = 1'b0;
  logic [31:0] req_addr = '0;
  logic [31:0] req_wdata = '0;
  logic        req_ready;
  logic        rsp_valid;
  logic [31:0] rsp_rdata;
  logic        rsp_err;
  logic [10:0] dmem_addr;
  logic        dmem_we;
  logic [31:0] dmem_wdata;
  logic [31:0] dmem_rdata = '0;
  logic [3:0]  key_in = 4'hF;
  logic [9:0]  sw_in = '0;
  logic [15:0] hex_out;
  logic [9:0]  ledr_out;

  logic [31:0] mem [0:2047];

  int          n_cmp = 0;
  int          n_bad = 0;
  logic [31:0] r_rdata;
  logic        r_err;
  int          r_lat;
  int          r_wecnt;
  logic [10:0] r_weaddr;
  logic [31:0] r_wedata;

  mmio_bus_controller dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_we(req_we), .req_addr(req_addr), .req_wdata(req_wdata),
    .req_ready(req_ready), .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
    .dmem_addr(dmem_addr), .dmem_we(dmem_we), .dmem_wdata(dmem_wdata), .dmem_rdata(dmem_rdata),
    .key_in(key_in), .sw_in(sw_in), .hex_out(hex_out), .ledr_out(ledr_out)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (dmem_we) mem[dmem_addr] <= dmem_wdata;
    dmem_rdata <= mem[dmem_addr];
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic do_req(input string tag, input logic we, input logic [31:0] addr,
                        input logic [31:0] wdata);
    int busy_ready;
    busy_ready = 0;
    @(negedge clk);
    check({tag, " ready"}, {31'b0, req_ready}, 32'd1);
    req_valid = 1'b1; req_we = we; req_addr = addr; req_wdata = wdata;
    @(posedge clk); #1;
    req_valid = 1'b0;
    r_lat = 0; r_wecnt = 0; r_err = 1'b0; r_rdata = '0; r_weaddr = '0; r_wedata = '0;
    for (int c = 1; c <= 8; c++) begin
      if (dmem_we) begin
        r_wecnt++; r_weaddr = dmem_addr; r_wedata = dmem_wdata;
      end
      if (req_ready) busy_ready++;
      if (rsp_valid) begin
        r_lat = c; r_rdata = rsp_rdata; r_err = rsp_err;
        break;
      end
      @(posedge clk); #1;
    end
    check({tag, " busy_ready"}, busy_ready, 32'd0);
    @(posedge clk); #1;
    check({tag, " single_pulse"}, {31'b0, rsp_valid}, 32'd0);
    check({tag, " idle_rdata"}, rsp_rdata, 32'd0);
  endtask

  initial begin
    for (int i = 0; i < 2048; i++) mem[i] = '0;

    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst ready", {31'b0, req_ready}, 32'd0);
    check("rst rsp_valid", {31'b0, rsp_valid}, 32'd0);
    check("rst dmem_we", {31'b0, dmem_we}, 32'd0);
    check("rst rdata", rsp_rdata, 32'd0);
    check("rst hex", {16'b0, hex_out}, 32'd0);
    check("rst ledr", {22'b0, ledr_out}, 32'd0);
    reset = 1'b0;

    do_req("st100", 1'b1, 32'h0000_0100, 32'hDEAD_BEEF);
    check("st100 lat", r_lat, 32'd1);
    check("st100 we_cnt", r_wecnt, 32'd1);
    check("st100 we_addr", {21'b0, r_weaddr}, 32'd64);
    check("st100 we_data", r_wedata, 32'hDEAD_BEEF);
    check("st100 err", {31'b0, r_err}, 32'd0);

    do_req("ld100", 1'b0, 32'h0000_0100, 32'h0);
    check("ld100 lat", r_lat, 32'd2);
    check("ld100 data", r_rdata, 32'hDEAD_BEEF);
    check("ld100 we_cnt", r_wecnt, 32'd0);
    check("ld100 err", {31'b0, r_err}, 32'd0);

    do_req("st1ffc", 1'b1, 32'h0000_1FFC, 32'hCAFE_F00D);
    check("st1ffc we_addr", {21'b0, r_weaddr}, 32'd2047);
    check("st1ffc lat", r_lat, 32'd1);
    do_req("ld1ffc", 1'b0, 32'h0000_1FFC, 32'h0);
    check("ld1ffc data", r_rdata, 32'hCAFE_F00D);

    do_req("st_hex", 1'b1, 32'hF000_0000, 32'h1234_ABCD);
    check("st_hex lat", r_lat, 32'd1);
    check("st_hex we_cnt", r_wecnt, 32'd0);
    check("hex_out", {16'b0, hex_out}, 32'h0000_ABCD);
    do_req("st_ledr", 1'b1, 32'hF000_0004, 32'h0000_03FF);
    check("ledr_out", {22'b0, ledr_out}, 32'h0000_03FF);
    do_req("ld_hex", 1'b0, 32'hF000_0000, 32'h0);
    check("ld_hex data", r_rdata, 32'h0000_ABCD);
    check("ld_hex lat", r_lat, 32'd1);
    do_req("ld_ledr", 1'b0, 32'hF000_0004, 32'h0);
    check("ld_ledr data", r_rdata, 32'h0000_03FF);

    sw_in = 10'h2A5; key_in = 4'b1101;
    repeat (3) @(posedge clk);
    do_req("ld_sw", 1'b0, 32'hF000_0014, 32'h0);
    check("ld_sw data", r_rdata, 32'h0000_02A5);
    do_req("ld_key", 1'b0, 32'hF000_0010, 32'h0);
    check("ld_key data", r_rdata, 32'h0000_0002);
    key_in = 4'hF;
    repeat (3) @(posedge clk);
    do_req("ld_key_rel", 1'b0, 32'hF000_0010, 32'h0);
    check("ld_key_rel data", r_rdata, 32'h0);

    do_req("ld_mis", 1'b0, 32'h0000_0102, 32'h0);
    check("ld_mis err", {31'b0, r_err}, 32'd1);
    check("ld_mis data", r_rdata, 32'h0);
    check("ld_mis we_cnt", r_wecnt, 32'd0);
    check("ld_mis lat", r_lat, 32'd1);
    do_req("st_unmap", 1'b1, 32'hF000_0008, 32'hFFFF_FFFF);
    check("st_unmap err", {31'b0, r_err}, 32'd1);
    check("st_unmap we_cnt", r_wecnt, 32'd0);
    check("st_unmap hex", {16'b0, hex_out}, 32'h0000_ABCD);
    check("st_unmap ledr", {22'b0, ledr_out}, 32'h0000_03FF);
    do_req("ld_2000", 1'b0, 32'h0000_2000, 32'h0);
    check("ld_2000 err", {31'b0, r_err}, 32'd1);
    do_req("st_mis_dmem", 1'b1, 32'h0000_0101, 32'h1111_1111);
    check("st_mis_dmem err", {31'b0, r_err}, 32'd1);
    check("st_mis_dmem we_cnt", r_wecnt, 32'd0);
    do_req("st_key", 1'b1, 32'hF000_0010, 32'hFFFF_FFFF);
    check("st_key err", {31'b0, r_err}, 32'd0);
    check("st_key hex", {16'b0, hex_out}, 32'h0000_ABCD);

    @(negedge clk);
    req_valid = 1'b1; req_we = 1'b1; req_addr = 32'h0000_0200; req_wdata = 32'h55AA_55AA;
    @(posedge clk); #1;
    req_valid = 1'b0;
    reset = 1'b1;
    #1;
    check("midrst dmem_we", {31'b0, dmem_we}, 32'd0);
    check("midrst rsp_valid", {31'b0, rsp_valid}, 32'd0);
    @(posedge clk); #1;
    reset = 1'b0;
    @(negedge clk);
    check("postrst ready", {31'b0, req_ready}, 32'd1);
    check("postrst rsp_valid", {31'b0, rsp_valid}, 32'd0);
    do_req("ld200", 1'b0, 32'h0000_0200, 32'h0);
    check("ld200 data", r_rdata, 32'h0);

`ifdef MMIO_KEY_STICKY_EN
    key_in = 4'b1110;
    repeat (3) @(posedge clk);
    key_in = 4'hF;
    repeat (3) @(posedge clk);
    do_req("sticky1", 1'b0, 32'hF000_0010, 32'h0);
    check("sticky1 data", r_rdata, 32'h0000_0001);
    do_req("sticky2", 1'b0, 32'hF000_0010, 32'h0);
    check("sticky2 data", r_rdata, 32'h0);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
